// File: rtl/lmc_pkg.sv
// Shared definitions for the LMC execute stage: opcodes, instruction field
// positions and the sequencing FSM state encoding.
package lmc_pkg;

   localparam int OPC_W   = 3;
   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 5;
   localparam int SEL_BIT = 4;

   localparam logic [OPC_W-1:0] OP_HLT = 3'b000;
   localparam logic [OPC_W-1:0] OP_LDA = 3'b001;
   localparam logic [OPC_W-1:0] OP_ADD = 3'b010;
   localparam logic [OPC_W-1:0] OP_SUB = 3'b011;
   localparam logic [OPC_W-1:0] OP_BRA = 3'b100;
   localparam logic [OPC_W-1:0] OP_BRZ = 3'b101;
   localparam logic [OPC_W-1:0] OP_BRC = 3'b110;
   localparam logic [OPC_W-1:0] OP_OUT = 3'b111;

   typedef enum logic [2:0] {
      S_FETCH    = 3'd0,
      S_EXEC     = 3'd1,
      S_COMMIT   = 3'd2,
      S_WAIT_OUT = 3'd3,
      S_HALT     = 3'd4
   } state_t;

endpackage

// File: rtl/lmc_alu.sv
// Combinational accumulator ALU: computes the new accumulator value and flags
// and tells the sequencer which of them the opcode is allowed to write.
module lmc_alu
   import lmc_pkg::*;
#(
   parameter int ACC_WIDTH = 4
) (
   input  logic [OPC_W-1:0]     op,
   input  logic [ACC_WIDTH-1:0] acc,
   input  logic [ACC_WIDTH-1:0] operand,
   output logic [ACC_WIDTH-1:0] result,
   output logic                 c_out,
   output logic                 z_out,
   output logic                 wr_acc,
   output logic                 wr_c
);

   // One extra bit holds the carry for ADD and the borrow for SUB.
   logic [ACC_WIDTH:0] wide;

   always_comb begin
      // NOTE: every output gets a default before the case, so no opcode path
      // leaves a signal unassigned and no latch is inferred.
      wide   = '0;
      wr_acc = 1'b0;
      wr_c   = 1'b0;
      case (op)
         OP_LDA: begin
            wide   = {1'b0, operand};
            wr_acc = 1'b1;
         end
         OP_ADD: begin
            wide   = {1'b0, acc} + {1'b0, operand};
            wr_acc = 1'b1;
            wr_c   = 1'b1;
         end
         OP_SUB: begin
            wide   = {1'b0, acc} - {1'b0, operand};
            wr_acc = 1'b1;
            wr_c   = 1'b1;
         end
         default: ;
      endcase
   end

   assign result = wide[ACC_WIDTH-1:0];
   assign c_out  = wide[ACC_WIDTH];
   assign z_out  = (result == '0);

endmodule

// File: rtl/lmc_exec_stage.sv
// LMC execute/sequencing stage: FETCH/EXEC/COMMIT FSM with an output-port
// handshake state and a terminal HALT; drives the PC advance/load pulses.
module lmc_exec_stage
   import lmc_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  timer555,
   input  logic                  reset_count,
   input  logic [DATA_WIDTH-1:0] instr,
   input  logic [ACC_WIDTH-1:0]  data_in,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  acc,
   output logic                  flag_z,
   output logic                  flag_c,
   output logic                  pc_advance,
   output logic                  pc_load,
   output logic [ADDR_WIDTH-1:0] pc_target,
   output logic [ACC_WIDTH-1:0]  out_data,
   output logic                  out_valid,
   output logic                  halted
);

   state_t                state;
   logic [DATA_WIDTH-1:0] ir;
   logic [OPC_W-1:0]      op;
   logic [ACC_WIDTH-1:0]  operand;
   logic [ACC_WIDTH-1:0]  alu_result;
   logic                  alu_c, alu_z, alu_wr_acc, alu_wr_c;
   logic                  branch_taken;

   assign op      = ir[OPC_MSB:OPC_LSB];
   assign operand = ir[SEL_BIT] ? ir[ACC_WIDTH-1:0] : data_in;

   // Branches look at the flags as they stand in EXEC, i.e. those left by
   // the previous instruction.
   assign branch_taken = (op == OP_BRA)
                       | ((op == OP_BRZ) & flag_z)
                       | ((op == OP_BRC) & flag_c);

   lmc_alu #(.ACC_WIDTH(ACC_WIDTH)) u_alu (
      .op      (op),
      .acc     (acc),
      .operand (operand),
      .result  (alu_result),
      .c_out   (alu_c),
      .z_out   (alu_z),
      .wr_acc  (alu_wr_acc),
      .wr_c    (alu_wr_c)
   );

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge timer555 or posedge reset_count) begin
      if (reset_count) begin
         state      <= S_FETCH;
         ir         <= '0;
         acc        <= '0;
         flag_z     <= 1'b0;
         flag_c     <= 1'b0;
         pc_advance <= 1'b0;
         pc_load    <= 1'b0;
         pc_target  <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         halted     <= 1'b0;
      end else begin
         // PC commands are single-cycle pulses raised on entry to COMMIT.
         pc_advance <= 1'b0;
         pc_load    <= 1'b0;
         case (state)
            S_FETCH: begin
               ir    <= instr;
               state <= S_EXEC;
            end
            S_EXEC: begin
               if (alu_wr_acc) begin
                  acc    <= alu_result;
                  flag_z <= alu_z;
               end
               if (alu_wr_c) flag_c <= alu_c;
               case (op)
                  OP_HLT: begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  OP_OUT: begin
                     out_data  <= acc;
                     out_valid <= 1'b1;
                     state     <= S_WAIT_OUT;
                  end
                  default: begin
                     if (branch_taken) begin
                        pc_load   <= 1'b1;
                        pc_target <= ir[ADDR_WIDTH-1:0];
                     end else begin
                        pc_advance <= 1'b1;
                     end
                     state <= S_COMMIT;
                  end
               endcase
            end
            S_WAIT_OUT: begin
               if (out_ready) begin
                  out_valid  <= 1'b0;
                  pc_advance <= 1'b1;
                  state      <= S_COMMIT;
               end
            end
            S_COMMIT: state <= S_FETCH;
            S_HALT:   state <= S_HALT;
            default:  state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_lmc_exec_stage.sv
// Directed bench for lmc_exec_stage: a vector table of single instructions
// plus hand sequences for the output handshake, HALT and asynchronous reset.
module tb_lmc_exec_stage;

   logic       timer555 = 1'b0;
   logic       reset_count;
   logic [7:0] instr;
   logic [3:0] data_in;
   logic       out_ready;
   logic [3:0] acc;
   logic       flag_z, flag_c;
   logic       pc_advance, pc_load;
   logic [1:0] pc_target;
   logic [3:0] out_data;
   logic       out_valid;
   logic       halted;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [7:0] instr;
      logic [3:0] din;
      logic [3:0] e_acc;
      logic       e_z;
      logic       e_c;
      logic       e_load;
      logic [1:0] e_tgt;
   } vec_t;

   vec_t vecs[16];

   lmc_exec_stage #(.DATA_WIDTH(8), .ACC_WIDTH(4), .ADDR_WIDTH(2)) dut (
      .timer555    (timer555),
      .reset_count (reset_count),
      .instr       (instr),
      .data_in     (data_in),
      .out_ready   (out_ready),
      .acc         (acc),
      .flag_z      (flag_z),
      .flag_c      (flag_c),
      .pc_advance  (pc_advance),
      .pc_load     (pc_load),
      .pc_target   (pc_target),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .halted      (halted)
   );

   always #5 timer555 = ~timer555;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge timer555);
      #1;
   endtask

   // Called while the DUT sits in FETCH. instr and data_in are scrambled
   // outside the cycles where they must be sampled.
   task automatic run_instr(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("v%0d(0x%02h)", idx, v.instr);
      instr   = v.instr;
      data_in = ~v.din;
      step();
      check({tag, " exec no pulse"}, {30'd0, pc_advance, pc_load}, 32'd0);
      instr   = ~v.instr;
      data_in = v.din;
      step();
      check({tag, " acc"}, {28'd0, acc}, {28'd0, v.e_acc});
      check({tag, " z/c"}, {30'd0, flag_z, flag_c}, {30'd0, v.e_z, v.e_c});
      check({tag, " adv/load"}, {30'd0, pc_advance, pc_load}, {30'd0, !v.e_load, v.e_load});
      if (v.e_load) check({tag, " target"}, {30'd0, pc_target}, {30'd0, v.e_tgt});
      step();
      check({tag, " fetch no pulse"}, {30'd0, pc_advance, pc_load}, 32'd0);
   endtask

   initial begin
      vec_t v;
      //           instr  din    acc   z     c     load  tgt
      vecs[0]  = '{8'h39, 4'h0, 4'd9,  1'b0, 1'b0, 1'b0, 2'd0}; // LDA #9
      vecs[1]  = '{8'h57, 4'h0, 4'd0,  1'b1, 1'b1, 1'b0, 2'd0}; // ADD #7 -> 16
      vecs[2]  = '{8'hA1, 4'h0, 4'd0,  1'b1, 1'b1, 1'b1, 2'd1}; // BRZ 1 taken
      vecs[3]  = '{8'h33, 4'h0, 4'd3,  1'b0, 1'b1, 1'b0, 2'd0}; // LDA #3, C kept
      vecs[4]  = '{8'h75, 4'h0, 4'd14, 1'b0, 1'b1, 1'b0, 2'd0}; // SUB #5 borrow
      vecs[5]  = '{8'hD2, 4'h0, 4'd14, 1'b0, 1'b1, 1'b1, 2'd2}; // BRC 2 taken
      vecs[6]  = '{8'hA1, 4'h0, 4'd14, 1'b0, 1'b1, 1'b0, 2'd0}; // BRZ 1 not taken
      vecs[7]  = '{8'h52, 4'h0, 4'd0,  1'b1, 1'b1, 1'b0, 2'd0}; // ADD #2 -> 16
      vecs[8]  = '{8'h70, 4'h0, 4'd0,  1'b1, 1'b0, 1'b0, 2'd0}; // SUB #0
      vecs[9]  = '{8'h83, 4'h0, 4'd0,  1'b1, 1'b0, 1'b1, 2'd3}; // BRA 3
      vecs[10] = '{8'hC0, 4'h0, 4'd0,  1'b1, 1'b0, 1'b0, 2'd0}; // BRC not taken
      vecs[11] = '{8'h36, 4'h0, 4'd6,  1'b0, 1'b0, 1'b0, 2'd0}; // LDA #6
      vecs[12] = '{8'h40, 4'h5, 4'd11, 1'b0, 1'b0, 1'b0, 2'd0}; // ADD data_in=5
      vecs[13] = '{8'h20, 4'h0, 4'd0,  1'b1, 1'b0, 1'b0, 2'd0}; // LDA data_in=0
      vecs[14] = '{8'h33, 4'h0, 4'd3,  1'b0, 1'b0, 1'b0, 2'd0}; // LDA #3
      vecs[15] = '{8'h36, 4'h0, 4'd6,  1'b0, 1'b0, 1'b0, 2'd0}; // LDA #6

      reset_count = 1'b1;
      instr       = 8'h00;
      data_in     = 4'h0;
      out_ready   = 1'b0;
      #12;
      check("reset outputs",
            {20'd0, acc, flag_z, flag_c, pc_advance, pc_load, pc_target, out_data, out_valid, halted},
            32'd0);
      @(negedge timer555);
      reset_count = 1'b0;

      for (int i = 0; i < 16; i++) run_instr(vecs[i], i);

      // OUT with the consumer stalling for four cycles.
      instr = 8'hE0;
      step();
      check("out exec valid", {31'd0, out_valid}, 32'd0);
      instr = 8'h00;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("out wait%0d valid/data", i), {27'd0, out_valid, out_data}, {27'd0, 1'b1, 4'd6});
         check($sformatf("out wait%0d no pulse", i), {30'd0, pc_advance, pc_load}, 32'd0);
      end
      out_ready = 1'b1;
      step();
      check("out accept valid", {31'd0, out_valid}, 32'd0);
      check("out accept adv/load", {30'd0, pc_advance, pc_load}, {30'd0, 2'b10});
      out_ready = 1'b0;
      step();
      check("out after adv", {31'd0, pc_advance}, 32'd0);

      // OUT with out_ready already high: exactly one cycle of out_valid.
      out_ready = 1'b1;
      instr     = 8'hE0;
      step();
      instr = 8'h00;
      step();
      check("out fast valid/data", {27'd0, out_valid, out_data}, {27'd0, 1'b1, 4'd6});
      check("out fast no pulse", {30'd0, pc_advance, pc_load}, 32'd0);
      step();
      check("out fast done", {29'd0, out_valid, pc_advance, pc_load}, {29'd0, 3'b010});
      out_ready = 1'b0;
      step();

      // LDA data_in = 0xB, then HLT; HALT must ignore instr forever.
      v = '{8'h20, 4'hB, 4'd11, 1'b0, 1'b0, 1'b0, 2'd0};
      run_instr(v, 16);
      instr = 8'h00;
      step();
      check("hlt exec halted", {31'd0, halted}, 32'd0);
      step();
      check("hlt halted", {31'd0, halted}, 32'd1);
      check("hlt no pulse", {30'd0, pc_advance, pc_load}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         instr = 8'($urandom);
         step();
         check($sformatf("halt cycle%0d", i),
               {26'd0, halted, pc_advance, pc_load, acc[2:0]}, {26'd0, 3'b100, 3'd3});
      end

      // Asynchronous reset out of HALT, observed before any clock edge.
      #2 reset_count = 1'b1;
      #1;
      check("reset from halt", {25'd0, halted, acc, flag_z, flag_c}, 32'd0);
      #1 reset_count = 1'b0;

      v = '{8'h3F, 4'h0, 4'd15, 1'b0, 1'b0, 1'b0, 2'd0}; // LDA #15
      run_instr(v, 17);
      v = '{8'h51, 4'h0, 4'd0, 1'b1, 1'b1, 1'b0, 2'd0};  // ADD #1 -> 16
      run_instr(v, 18);

      // Reset mid-EXEC: flags were 1 and must clear immediately.
      instr = 8'h35;
      step();
      #2 reset_count = 1'b1;
      #1;
      check("reset mid-exec",
            {24'd0, acc, flag_z, flag_c, pc_advance, pc_load}, 32'd0);
      #1 reset_count = 1'b0;
      v = '{8'h35, 4'h0, 4'd5, 1'b0, 1'b0, 1'b0, 2'd0};  // restarts from FETCH
      run_instr(v, 19);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
